pwm_sine_out: RTL
=================

Name: pwm_sine_out

Overview:
- Downstream stage of the sine LUT reader. It consumes the 10-bit sine samples (pwm_sin_val with data_valid) and turns them into a fixed-frequency PWM output.
- Samples are buffered in a small FIFO. One sample is applied per PWM period, so each period carries exactly one sine point.
- Duty changes are double-buffered and take effect only at a period boundary, so the output never glitches.

Parameters:
- WIDTH, 10, sample and PWM counter width; period = 2^WIDTH counter steps.
- FIFO_DEPTH, 4, sample buffer entries; must be a power of 2, ≥2.
- PRESCALE, 1, clk cycles per counter step; ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  runs the PWM counter; 0 = output idle.
- data_valid  in  1  pwm_sin_val holds a valid sample this cycle.
- pwm_sin_val  in  WIDTH  duty sample; value N gives N high steps per period.
- data_ready  out  1  FIFO can accept a sample this cycle.
- pwm_out  out  1  registered PWM output.
- period_start  out  1  one-cycle pulse when a new period begins (duty load).
- underrun  out  1  sticky flag: a period started with the FIFO empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - pwm_out=0, period_start=0, underrun=0.
  - FIFO empty: fifo_level=0, data_ready=1.
  - duty_active=0, cnt=2^WIDTH-1, prescaler=0.
- Reset mid-operation discards all buffered samples and takes effect immediately; no partial period resumes.
- Push handshake:
  - A sample is written when data_valid && data_ready at a clk edge.
  - data_ready = (fifo_level != FIFO_DEPTH), derived from registered level only; there is no combinational path from data_valid.
  - data_valid while data_ready=0 drops the sample; it is not queued.
- Prescaler: counts 0..PRESCALE-1 while enable=1. tick = enable && (prescaler == PRESCALE-1).
- Counter:
  - cnt advances by 1 on each tick and wraps 2^WIDTH-1 → 0.
  - While enable=0: cnt is held at 2^WIDTH-1, prescaler at 0, pwm_out=0. The first tick after enable therefore starts a fresh period.
- Period boundary (tick && cnt == 2^WIDTH-1):
  - FIFO non-empty: pop the head into duty_active.
  - FIFO empty: keep duty_active and set underrun=1.
  - Either case: period_start=1 for exactly the next cycle.
- Output:
  - pwm_out <= enable && (cnt < duty_active), evaluated on registered values, so it trails cnt by one clk.
  - duty 0 gives constant low; duty 2^WIDTH-1 gives high for all but one step.
- Simultaneous events:
  - Push and pop in the same cycle: the level is unchanged and both complete. A pop from an empty FIFO does not see the sample pushed that cycle, so it still counts as an underrun.
  - Push attempt while full coinciding with a pop: rejected, because data_ready was 0.
- underrun is sticky. It clears only on reset or on a cycle with enable=0.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. The level is a separate counter, not a pointer difference.
- The FIFO keeps accepting samples while enable=0, which allows preloading before start.

Decomposition:
- Shared package pwm_pkg:
  - SAMPLE_W=10 (matches the LUT data width).
  - typedef sample_t = logic [SAMPLE_W-1:0].
  - PWM_PERIOD = 2**SAMPLE_W.
- One natural sub-module: sample_fifo, a synchronous FIFO (clk, reset, push, din, pop, dout, level, full, empty).
- The PWM counter, prescaler and duty register stay in the top module.

Test Plan:
- Reset check: hold reset=0 with random inputs → pwm_out=0, data_ready=1, fifo_level=0, underrun=0. Release reset → all outputs unchanged until enable.
- Single sample: push 10'd256, then enable=1 (PRESCALE=1) → period_start pulses once; pwm_out high exactly 256 consecutive clks of each 1024; underrun=1 at the second period start.
- Backpressure: hold data_valid=1 with values 1,2,3,4,5 and enable=0 → fifo_level reaches 4, data_ready=0, value 5 dropped. Enable → duties 1,2,3,4 in successive periods.
- Extremes: samples 0 then 1023 → period 1 has no high cycles; period 2 is high for 1023 clks, low for 1.
- Prescale: PRESCALE=3, sample 2 → pwm_out high for 6 clks; period_start every 3072 clks.
- Reset mid-period: push 512, enable, assert reset at cnt=100 → pwm_out drops to 0 asynchronously. After release, re-enable with an empty FIFO → duty_active=0, output stays low, underrun=1 at the first period start.

Source files
------------

// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the sine PWM output path.
//   SAMPLE_W   : width of one sine sample (same as the LUT data width)
//   sample_t   : one sine sample / duty value
//   PWM_PERIOD : counter steps in one PWM period
//   level_w()  : width needed to hold a FIFO occupancy of 0..depth
// ---------------------------------------------------------------------------
package pwm_pkg;

  localparam int SAMPLE_W   = 10;
  typedef logic [SAMPLE_W-1:0] sample_t;
  localparam int PWM_PERIOD = 2 ** SAMPLE_W;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pwm_sine_out_if.sv
// ---------------------------------------------------------------------------
// pwm_sine_out_if
// Valid/ready sample stream from the sine LUT reader into the PWM stage.
//   data_valid  : pwm_sin_val carries a sample this cycle
//   pwm_sin_val : duty sample (N = N high steps per period)
//   data_ready  : receiver can take a sample this cycle
// Modports: master = sample source, slave = PWM stage.
// ---------------------------------------------------------------------------
interface pwm_sine_out_if
  import pwm_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W
);

  logic             data_valid;
  logic [WIDTH-1:0] pwm_sin_val;
  logic             data_ready;

  modport master (
    output data_valid,
    output pwm_sin_val,
    input  data_ready
  );

  modport slave (
    input  data_valid,
    input  pwm_sin_val,
    output data_ready
  );

endinterface

// File: rtl/sample_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
// Small synchronous first-word-fall-through FIFO for PWM duty samples.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low; empties the FIFO
//   push  : write din (ignored when full)
//   din   : sample to write
//   pop   : drop the head entry (ignored when empty)
//   dout  : current head entry, valid whenever empty=0
//   level : occupancy 0..DEPTH
//   full  : level == DEPTH
//   empty : level == 0
// ---------------------------------------------------------------------------
module sample_fifo
  import pwm_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] LVL_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   level_reg;

  logic push_ok;
  logic pop_ok;

  assign full    = (level_reg == LVL_FULL);
  assign empty   = (level_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // The duty register loads the head on the same edge as the pop, so the
  // head is read straight out of the array (a handful of LUT-RAM entries).
  assign dout  = mem[rd_ptr_reg];
  assign level = level_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap without compare
  // logic; occupancy is tracked in its own counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/pwm_sine_out.sv
// ---------------------------------------------------------------------------
// pwm_sine_out
// Turns a stream of sine samples into a fixed-frequency PWM output, one
// sample per PWM period. Samples are buffered in a small FIFO; the duty
// register only loads at a period boundary so the output never glitches.
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-low
//   enable       : runs the PWM counter; 0 = output idle, counter parked
//   smp          : sample stream (data_valid / pwm_sin_val / data_ready)
//   pwm_out      : registered PWM output
//   period_start : one-cycle pulse after each period boundary (duty load)
//   underrun     : sticky, a period began with the FIFO empty; cleared by
//                  reset or any cycle with enable=0
//   fifo_level   : current FIFO occupancy
// ---------------------------------------------------------------------------
module pwm_sine_out
  import pwm_pkg::*;
#(
  parameter int WIDTH      = SAMPLE_W,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  pwm_sine_out_if.slave               smp,
  output logic                        pwm_out,
  output logic                        period_start,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [PS_W-1:0]  prescale_reg;
  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] duty_reg;
  logic             pwm_reg;
  logic             period_start_reg;
  logic             underrun_reg;

  logic             tick;
  logic             boundary;
  logic             push;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_dout;

  // Ready depends only on registered occupancy, never on data_valid.
  assign smp.data_ready = !fifo_full;
  assign push           = smp.data_valid && !fifo_full;

  assign tick     = enable && (prescale_reg == PS_LAST);
  assign boundary = tick && (cnt_reg == CNT_MAX);

  sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (smp.pwm_sin_val),
    .pop   (boundary),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Prescaler and period counter. While idle the counter is parked at its
  // last step, so the first tick after enable is always a period boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale_reg <= '0;
      cnt_reg      <= CNT_MAX;
    end else if (!enable) begin
      prescale_reg <= '0;
      cnt_reg      <= CNT_MAX;
    end else if (tick) begin
      prescale_reg <= '0;
      cnt_reg      <= cnt_reg + 1'b1;
    end else begin
      prescale_reg <= prescale_reg + 1'b1;
    end
  end

  // Duty register: second stage of the double buffer. An empty FIFO at the
  // boundary repeats the previous duty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_reg <= '0;
    end else if (boundary && !fifo_empty) begin
      duty_reg <= fifo_dout;
    end
  end

  // Output, period pulse and sticky underrun. pwm_out compares the
  // registered counter and duty, so it trails the counter by one clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_reg          <= 1'b0;
      period_start_reg <= 1'b0;
      underrun_reg     <= 1'b0;
    end else if (!enable) begin
      pwm_reg          <= 1'b0;
      period_start_reg <= 1'b0;
      underrun_reg     <= 1'b0;
    end else begin
      pwm_reg          <= (cnt_reg < duty_reg);
      period_start_reg <= boundary;
      if (boundary && fifo_empty) begin
        underrun_reg <= 1'b1;
      end
    end
  end

  assign pwm_out      = pwm_reg;
  assign period_start = period_start_reg;
  assign underrun     = underrun_reg;

endmodule
